simmem_burst_sched: RTL
=======================

// Module: simmem_burst_sched
// PURPOSE
//  Round-robin scheduler sharing one simulation-memory read port among NREQ requesters.
//  Each requester asks for a burst (base address, length). The scheduler grants one burst
//  at a time and drives sequential read addresses and read-enable to the memory.
//  It returns a channel tag, valid and last flag aligned with memory read data.
//  Sits between the trigger/channel logic and the simulation pattern memory.
// PARAMETERS
//  NREQ      4        number of requesters (2..8)
//  AW        16       memory address width
//  LW        8        burst length width; length counts words
//  RD_LAT    2        memory read latency, rena->data, in clk cycles (>=1)
//  IDLE_ADDR 16'h03FF address driven while no burst is active
// PORTS
//  clk        in   1         clock
//  rst        in   1         reset, synchronous, active-high
//  req        in   NREQ      level request per requester; held until its gnt bit pulses
//  req_base   in   NREQ*AW   burst start address; slice i = [i*AW +: AW]
//  req_len    in   NREQ*LW   burst length in words; slice i = [i*LW +: LW]
//  gnt        out  NREQ      one-hot, 1-cycle pulse; base/len of that requester latched
//  busy       out  1         high from gnt cycle until last read pipeline stage drains
//  mem_addr   out  AW        memory read address (registered)
//  mem_rena   out  1         memory read enable (registered)
//  out_valid  out  1         mem_rena delayed RD_LAT cycles; marks valid memory data
//  out_ch     out  $clog2(NREQ) channel tag aligned with out_valid
//  out_last   out  1         marks final word of the burst, aligned with out_valid
//  done       out  NREQ      1-cycle pulse on owning channel, coincident with out_last
// BEHAVIOUR
//  Reset: gnt=0, busy=0, mem_rena=0, mem_addr=IDLE_ADDR, out_valid/out_last/done=0,
//   out_ch=0, RR pointer=0. The state goes to IDLE. The tag pipeline is cleared.
//  Reset mid-burst: the burst is aborted. No further out_valid, out_last or done.
//  FSM: IDLE, BURST.
//   IDLE: if any req bit is set, pick the first requester at or after the RR pointer
//    (wrapping) and pulse gnt for that cycle. Latch base and len, set the pointer to
//    the winner+1 mod NREQ, then go to BURST. If len=0, go instead to IDLE next cycle
//    with no reads. done for that channel pulses RD_LAT cycles later; out_valid stays 0.
//   BURST: in each cycle mem_rena=1 and mem_addr=base+k, k=0..len-1.
//    The address wraps modulo 2^AW. The cycle with k=len-1 tags last=1.
//    After that cycle the FSM returns to IDLE.
//  Latency: gnt in cycle T. First mem_rena/mem_addr=base in T+1. First out_valid in T+1+RD_LAT.
//  Back-to-back: exactly one idle cycle (mem_rena=0, mem_addr=IDLE_ADDR) between
//   consecutive bursts. This IDLE cycle is the arbitration cycle.
//  When no burst is active: mem_rena=0 and mem_addr=IDLE_ADDR.
//  busy=1 from the gnt cycle until the cycle after the final out_valid.
//  req changes during a burst are ignored until the next IDLE cycle. base/len are not re-sampled.
//  A requester that is still high in the cycle after its gnt is treated as a new request.
//  Max burst is 2^LW-1 words. The k counter is LW bits wide and never overflows.
// STRUCTURE
//  Package simmem_pkg: AW/LW defaults, IDLE_ADDR, state enum {IDLE,BURST}.
//  Sub-module rr_arbiter: NREQ req vector plus pointer in, one-hot grant and index out,
//   purely combinational.
//  Tag pipeline {valid, ch, last}: RD_LAT-deep shift register inside the top level.
// TESTING
//  1. Req0 only, base=0x0010, len=4 -> gnt[0] in T. mem_addr 0x10..0x13 with rena in T+1..T+4.
//     out_valid T+3..T+6 (RD_LAT=2); out_last and done[0] in T+6.
//  2. req=4'b1111 held, all len=2 -> grants in order 0,1,2,3,0. One idle cycle between bursts.
//  3. Req2 with len=0 -> gnt[2] pulses. mem_rena is never asserted; done[2] fires 2 cycles later.
//  4. base=0xFFFE, len=4 -> addresses FFFE, FFFF, 0000, 0001. out_last on the 4th word.
//  5. rst asserted on the 3rd address of a len=8 burst -> next cycle mem_rena=0,
//     mem_addr=IDLE_ADDR, busy=0. No done. Pointer=0; with req=4'b1010 after reset, req1 is granted first.
//  6. Req1 during req3's burst -> no gnt until req3's last address cycle plus one.
//     Req1 is then granted and its base/len are sampled in that cycle.

Source files
------------

// File: rtl/simmem_burst_sched_pkg.sv
// Shared defaults and FSM state type for the simulation-memory burst scheduler.
package simmem_pkg;
  localparam int              AW_DEF        = 16;
  localparam int              LW_DEF        = 8;
  localparam logic [15:0]     IDLE_ADDR_DEF = 16'h03FF;

  typedef enum logic [0:0] {IDLE, BURST} state_e;
endpackage

// File: rtl/simmem_burst_sched_if.sv
// Requester handshake, memory read port and tagged read-data side of the scheduler.
interface simmem_burst_sched_if
  import simmem_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int AW   = AW_DEF,
  parameter int LW   = LW_DEF
);
  localparam int CW = $clog2(NREQ);

  logic [NREQ-1:0]    req;
  logic [NREQ*AW-1:0] req_base;
  logic [NREQ*LW-1:0] req_len;
  logic [NREQ-1:0]    gnt;
  logic               busy;
  logic [AW-1:0]      mem_addr;
  logic               mem_rena;
  logic               out_valid;
  logic [CW-1:0]      out_ch;
  logic               out_last;
  logic [NREQ-1:0]    done;

  modport master (
    output req, req_base, req_len,
    input  gnt, busy, mem_addr, mem_rena, out_valid, out_ch, out_last, done
  );

  modport slave (
    input  req, req_base, req_len,
    output gnt, busy, mem_addr, mem_rena, out_valid, out_ch, out_last, done
  );
endinterface

// File: rtl/simmem_burst_sched_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after the pointer, wrapping.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int CW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [CW-1:0]   ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [CW-1:0]   idx_o,
  output logic            any_o
);
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      int j;
      j = int'(ptr_i) + i;
      if (j >= NREQ) j = j - NREQ;
      if (!any_o && req_i[j]) begin
        any_o    = 1'b1;
        idx_o    = CW'(j);
        gnt_o[j] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/simmem_burst_sched.sv
// Round-robin burst scheduler for a shared simulation-memory read port, with a
// {valid, ch, last} tag pipeline aligned to the memory read latency.
module simmem_burst_sched
  import simmem_pkg::*;
#(
  parameter int            NREQ      = 4,
  parameter int            AW        = AW_DEF,
  parameter int            LW        = LW_DEF,
  parameter int            RD_LAT    = 2,
  parameter logic [AW-1:0] IDLE_ADDR = AW'(IDLE_ADDR_DEF)
) (
  input  logic                 clk,
  input  logic                 rst,
  simmem_burst_sched_if.slave  bus
);
  localparam int CW = $clog2(NREQ);

  state_e        state_q;
  logic [CW-1:0] ptr_q;
  logic [AW-1:0] addr_q;
  logic          rena_q;
  logic          last_q;
  logic [CW-1:0] ch_q;
  logic [LW-1:0] len_q;
  logic [LW-1:0] k_q;

  logic [NREQ-1:0] win_oh;
  logic [CW-1:0]   win_idx;
  logic            win_any;
  logic [AW-1:0]   win_base;
  logic [LW-1:0]   win_len;
  logic            take;
  logic            zlen_take;

  logic [RD_LAT-1:0]         vld_pipe_q;
  logic [RD_LAT-1:0]         last_pipe_q;
  logic [RD_LAT-1:0][CW-1:0] ch_pipe_q;

  rr_arbiter #(.NREQ(NREQ), .CW(CW)) u_arb (
    .req_i (bus.req),
    .ptr_i (ptr_q),
    .gnt_o (win_oh),
    .idx_o (win_idx),
    .any_o (win_any)
  );

  always_comb begin
    win_base = bus.req_base[AW-1:0];
    win_len  = bus.req_len[LW-1:0];
    for (int i = 0; i < NREQ; i++) begin
      if (win_idx == CW'(i)) begin
        win_base = bus.req_base[i*AW +: AW];
        win_len  = bus.req_len[i*LW +: LW];
      end
    end
  end

  // Arbitration only happens in the IDLE cycle, so gnt is a pulse by construction.
  assign take      = (state_q == IDLE) && win_any && !rst;
  assign zlen_take = take && (win_len == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      addr_q  <= IDLE_ADDR;
      rena_q  <= 1'b0;
      last_q  <= 1'b0;
      ch_q    <= '0;
      len_q   <= '0;
      k_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (take) begin
            ptr_q <= (win_idx == CW'(NREQ-1)) ? '0 : win_idx + 1'b1;
            ch_q  <= win_idx;
            len_q <= win_len;
            k_q   <= '0;
            if (win_len != '0) begin
              state_q <= BURST;
              rena_q  <= 1'b1;
              addr_q  <= win_base;
              last_q  <= (win_len == LW'(1));
            end
          end
        end
        BURST: begin
          if (last_q) begin
            state_q <= IDLE;
            rena_q  <= 1'b0;
            addr_q  <= IDLE_ADDR;
            last_q  <= 1'b0;
          end else begin
            addr_q <= addr_q + 1'b1;
            k_q    <= k_q + 1'b1;
            // Next word is last when k+1 == len-1; LW+1 bits keeps len=2^LW-1 safe.
            last_q <= (({1'b0, k_q} + (LW+1)'(2)) == {1'b0, len_q});
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // A zero-length grant injects a done-only marker one stage early so that
  // done lands RD_LAT cycles after gnt; the slot is free because rena is low in IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe_q  <= '0;
      last_pipe_q <= '0;
      ch_pipe_q   <= '0;
    end else begin
      vld_pipe_q[0]  <= rena_q;
      last_pipe_q[0] <= (rena_q && last_q) || zlen_take;
      ch_pipe_q[0]   <= zlen_take ? win_idx : ch_q;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_pipe_q[i]  <= vld_pipe_q[i-1];
        last_pipe_q[i] <= last_pipe_q[i-1];
        ch_pipe_q[i]   <= ch_pipe_q[i-1];
      end
    end
  end

  assign bus.gnt       = take ? win_oh : '0;
  assign bus.busy      = take || (state_q == BURST) || (|vld_pipe_q) || (|last_pipe_q);
  assign bus.mem_addr  = addr_q;
  assign bus.mem_rena  = rena_q;
  assign bus.out_valid = vld_pipe_q[RD_LAT-1];
  assign bus.out_ch    = ch_pipe_q[RD_LAT-1];
  assign bus.out_last  = vld_pipe_q[RD_LAT-1] && last_pipe_q[RD_LAT-1];

  always_comb begin
    bus.done = '0;
    if (last_pipe_q[RD_LAT-1]) bus.done = NREQ'(1) << ch_pipe_q[RD_LAT-1];
  end
endmodule
